// File: rtl/cmem_dbuf_if.sv
// Bus bundle for the double-buffered coefficient memory.
//   master : driver side (FIR controller / bench)
//     cen_n, wen_n, d, wptr_clr, swap_req, addr  -> memory
//     q, bank_sel, wptr, wr_full, wr_ovf         <- memory
//   slave  : memory side (cmem_dbuf), directions reversed.
// addr packs NPORTS read addresses (port p at [p*ADDR_W +: ADDR_W]),
// q packs NPORTS registered words (port p at [p*DATA_W +: DATA_W]).
interface cmem_dbuf_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int NPORTS = 8
) ();
  logic                     cen_n;
  logic                     wen_n;
  logic [DATA_W-1:0]        d;
  logic                     wptr_clr;
  logic                     swap_req;
  logic [NPORTS*ADDR_W-1:0] addr;
  logic [NPORTS*DATA_W-1:0] q;
  logic                     bank_sel;
  logic [ADDR_W-1:0]        wptr;
  logic                     wr_full;
  logic                     wr_ovf;

  modport master (
    output cen_n, wen_n, d, wptr_clr, swap_req, addr,
    input  q, bank_sel, wptr, wr_full, wr_ovf
  );

  modport slave (
    input  cen_n, wen_n, d, wptr_clr, swap_req, addr,
    output q, bank_sel, wptr, wr_full, wr_ovf
  );
endinterface

// File: rtl/cmem_dbuf.sv
// Double-buffered coefficient memory with NPORTS registered read ports.
// Taps read the active bank while a new set streams into the shadow bank
// through an auto-incrementing write pointer; swap_req exchanges banks.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (q, bank_sel, wptr, flags)
//   bus   : cmem_dbuf_if.slave (enables, write data, read addrs, q, status)
module cmem_dbuf #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int NPORTS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  cmem_dbuf_if.slave bus
);

  // Index width into a bank; narrower than ADDR_W when DEPTH < 2**ADDR_W.
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] bank0 [DEPTH];
  logic [DATA_W-1:0] bank1 [DEPTH];

  logic                           bank_sel;
  logic [ADDR_W-1:0]              wptr;
  logic                           wr_full;
  logic                           wr_ovf;
  logic [NPORTS-1:0][DATA_W-1:0]  q_r;
  logic [NPORTS-1:0][ADDR_W-1:0]  raddr;

  logic en, wr_try, wr_do;

  assign raddr  = bus.addr;
  assign en     = !bus.cen_n;
  assign wr_try = en && !bus.wen_n;
  assign wr_do  = wr_try && !wr_full;

  // Shadow write: the bank not selected for reading. Uses the pre-edge
  // bank_sel/wptr, so a write coinciding with swap or clear lands in the
  // old shadow at the old pointer.
  always_ff @(posedge clk) begin
    if (wr_do) begin
      if (bank_sel) bank0[wptr[IW-1:0]] <= bus.d;
      else          bank1[wptr[IW-1:0]] <= bus.d;
    end
  end

  // Read ports: one registered stage, out-of-range addresses return 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= '0;
    end else if (en) begin
      for (int p = 0; p < NPORTS; p++) begin
        if (int'(raddr[p]) >= DEPTH)
          q_r[p] <= '0;
        else if (bank_sel)
          q_r[p] <= bank1[raddr[p][IW-1:0]];
        else
          q_r[p] <= bank0[raddr[p][IW-1:0]];
      end
    end
  end

  // Pointer / flag control. Swap and clear both win over the pointer
  // advance; a write dropped while full only raises wr_ovf when neither
  // swap nor clear is present in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_sel <= 1'b0;
      wptr     <= '0;
      wr_full  <= 1'b0;
      wr_ovf   <= 1'b0;
    end else if (en) begin
      if (bus.swap_req) begin
        bank_sel <= ~bank_sel;
        wptr     <= '0;
        wr_full  <= 1'b0;
        wr_ovf   <= 1'b0;
      end else if (bus.wptr_clr) begin
        wptr     <= '0;
        wr_full  <= 1'b0;
        wr_ovf   <= 1'b0;
      end else if (wr_try) begin
        if (wr_full) begin
          wr_ovf <= 1'b1;
        end else if (wptr == LAST) begin
          wptr    <= '0;
          wr_full <= 1'b1;
        end else begin
          wptr <= wptr + 1'b1;
        end
      end
    end
  end

  assign bus.q        = q_r;
  assign bus.bank_sel = bank_sel;
  assign bus.wptr     = wptr;
  assign bus.wr_full  = wr_full;
  assign bus.wr_ovf   = wr_ovf;

endmodule
